// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Purpose  : Single-cycle data-memory responder with byte-lane writes, range
//            checking and an optional post-reset clear pass (DMEM_CLEAR_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dmem_addr_i,
  input  logic        dmem_read_enable_i,
  input  logic [31:0] dmem_write_data_i,
  input  logic [3:0]  dmem_write_mask_i,
  output logic [31:0] dmem_read_data_o,
  output logic        dmem_read_valid_o,
  output logic        fault_o,
  output logic        ready_o
);

  localparam int          c_IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [32:0] c_SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  logic [31:0]        r_mem [DEPTH_WORDS];
  logic [31:0]        r_read_data;
  logic               r_read_valid;
  logic               r_fault;

  logic [31:0]        w_offset;
  logic               w_in_range;
  logic [c_IDX_W-1:0] w_idx;
  logic               w_ready;
  logic               w_accept;
  logic               w_load;
  logic [3:0]         w_lane_we;
  logic               w_clear_we;
  logic [c_IDX_W-1:0] w_clear_idx;

  // Offset wraps modulo 2^32, so addresses below BASE_ADDR land out of range.
  assign w_offset   = dmem_addr_i - BASE_ADDR;
  assign w_in_range = ({1'b0, w_offset} < c_SPAN_BYTES);
  assign w_idx      = w_offset[c_IDX_W+1:2];

`ifdef DMEM_CLEAR_EN
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DEPTH_WORDS - 1);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t             r_state;
  logic [c_IDX_W-1:0] r_clear_idx;
  logic               r_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= CLEAR;
      r_clear_idx <= '0;
      r_ready     <= 1'b0;
    end else if (r_state == CLEAR) begin
      r_clear_idx <= r_clear_idx + c_IDX_W'(1);
      if (r_clear_idx == c_LAST_IDX) begin
        r_state <= SERVE;
        r_ready <= 1'b1;
      end
    end
  end

  assign w_ready     = r_ready;
  assign w_clear_we  = (r_state == CLEAR) && !rst_i;
  assign w_clear_idx = r_clear_idx;
`else
  assign w_ready     = 1'b1;
  assign w_clear_we  = 1'b0;
  assign w_clear_idx = '0;
`endif

  assign ready_o   = w_ready;
  assign w_accept  = w_ready && !rst_i && (dmem_read_enable_i || (dmem_write_mask_i != 4'b0000));
  assign w_load    = w_accept && dmem_read_enable_i;
  assign w_lane_we = (w_accept && w_in_range) ? dmem_write_mask_i : 4'b0000;

  // Array has no reset: contents only change through stores or the clear pass.
  always_ff @(posedge clk_i) begin
    if (w_clear_we) begin
      r_mem[w_clear_idx] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (w_lane_we[b]) begin
          r_mem[w_idx][8*b +: 8] <= dmem_write_data_i[8*b +: 8];
        end
      end
    end
  end

  // Reading the old word here gives read-first behaviour on a same-word store.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_read_valid <= w_load;
      r_fault      <= w_accept && !w_in_range;
      if (w_load) begin
        r_read_data <= w_in_range ? r_mem[w_idx] : 32'h0;
      end
    end
  end

  assign dmem_read_data_o  = r_read_data;
  assign dmem_read_valid_o = r_read_valid;
  assign fault_o           = r_fault;

endmodule

`default_nettype wire
